// File: rtl/uart_recv_pkg.sv
// uart_recv_pkg: shared state encodings and default timeout for uart_recv_word
package uart_recv_pkg;
    typedef enum logic {
        ASM_IDLE,
        ASM_HIGH
    } asm_state_t;

    typedef enum logic [1:0] {
        HS_READY,
        HS_START,
        HS_WAIT_BUSY,
        HS_WAIT_DONE
    } hs_state_t;

    localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd5000;
endpackage

// File: rtl/byte_gap_timer.sv
// byte_gap_timer: counts enabled cycles; expire is high in the cycle the count reaches TERMINAL
// Ports: clk, reset (async active-low), clear (zero the count), enable (count this cycle),
//        expire (combinational terminal-count flag, only while enabled)
module byte_gap_timer #(
    parameter logic [15:0] TERMINAL = 16'd5000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [15:0] count;

    assign expire = enable && count == TERMINAL - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else count <= clear ? '0 : enable ? count + 16'd1 : count;
    end
endmodule

// File: rtl/uart_recv_word.sv
// uart_recv_word: pairs UART bytes into 16-bit words and hands them to an SPI master
// Ports: clk, reset (async active-low), rx_data/rx_valid (byte stream),
//        spi_busy (SPI master busy), tx_word/start (word + one-cycle request),
//        pending (word held), overrun (sticky drop flag), err_timeout (partial word discarded)
// Build option: define UART_RECV_TIMEOUT_EN to enable the inter-byte timeout.
module uart_recv_word
    import uart_recv_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        spi_busy,
    output logic [15:0] tx_word,
    output logic        start,
    output logic        pending,
    output logic        overrun,
    output logic        err_timeout
);
    asm_state_t asm_q, asm_d;
    hs_state_t  hs_q, hs_d;
    logic [7:0] high_q;
    logic       word_done, pend_clear, accept, timeout_fire;

    assign word_done  = asm_q == ASM_HIGH && rx_valid;
    assign pend_clear = hs_q == HS_WAIT_DONE && !spi_busy;
    // A word finishing on the edge the previous one is released still fits.
    assign accept     = word_done && (!pending || pend_clear);
    assign start      = hs_q == HS_START;

`ifdef UART_RECV_TIMEOUT_EN
    byte_gap_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (asm_q != ASM_HIGH || rx_valid),
        .enable (asm_q == ASM_HIGH),
        .expire (timeout_fire)
    );

    // A low byte arriving on the expiry cycle completes the word instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_timeout <= 1'b0;
        else err_timeout <= timeout_fire && !rx_valid;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_fire   = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        asm_d = rx_valid ? (asm_q == ASM_IDLE ? ASM_HIGH : ASM_IDLE)
                         : (timeout_fire ? ASM_IDLE : asm_q);
    end

    always_comb begin
        hs_d = hs_q;
        case (hs_q)
            HS_READY:     hs_d = !spi_busy && (pending || accept) ? HS_START : HS_READY;
            HS_START:     hs_d = HS_WAIT_BUSY;
            HS_WAIT_BUSY: hs_d = spi_busy ? HS_WAIT_DONE : HS_WAIT_BUSY;
            HS_WAIT_DONE: hs_d = spi_busy ? HS_WAIT_DONE : HS_READY;
            default:      hs_d = HS_READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q   <= ASM_IDLE;
            hs_q    <= HS_READY;
            high_q  <= '0;
            tx_word <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            hs_q    <= hs_d;
            high_q  <= asm_q == ASM_IDLE && rx_valid ? rx_data : high_q;
            tx_word <= accept ? {high_q, rx_data} : tx_word;
            pending <= accept || (pending && !pend_clear);
            overrun <= overrun || (word_done && !accept);
        end
    end
endmodule

// File: tb/tb_uart_recv_word.sv
// tb_uart_recv_word: directed self-checking bench for uart_recv_word
module tb_uart_recv_word;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        spi_busy = 1'b0;
    logic [15:0] tx_word;
    logic        start, pending, overrun, err_timeout;
    int          tests = 0;
    int          fails = 0;
    int          starts;
    int          errs;

    uart_recv_word #(.TIMEOUT_CYCLES(16'd10)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .spi_busy    (spi_busy),
        .tx_word     (tx_word),
        .start       (start),
        .pending     (pending),
        .overrun     (overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic count_starts(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (start) starts++;
        end
    endtask

    task automatic finish_xfer();
        spi_busy = 1'b1;
        step(2);
        spi_busy = 1'b0;
        step(1);
    endtask

    initial begin
        #3;
        chk("rst_tx_word", tx_word, 16'h0000);
        chk("rst_start", {15'd0, start}, 16'd0);
        chk("rst_pending", {15'd0, pending}, 16'd0);
        chk("rst_overrun", {15'd0, overrun}, 16'd0);
        chk("rst_err", {15'd0, err_timeout}, 16'd0);
        step(2);
        reset = 1'b1;
        step(1);

        send(8'hA5);
        chk("a5_no_start", {15'd0, start}, 16'd0);
        chk("a5_no_pending", {15'd0, pending}, 16'd0);
        send(8'h3C);
        chk("a53c_start", {15'd0, start}, 16'd1);
        chk("a53c_word", tx_word, 16'hA53C);
        chk("a53c_pending", {15'd0, pending}, 16'd1);
        step(1);
        chk("a53c_start_once", {15'd0, start}, 16'd0);
        spi_busy = 1'b1;
        step(3);
        chk("a53c_pend_busy", {15'd0, pending}, 16'd1);
        spi_busy = 1'b0;
        step(1);
        chk("a53c_pend_clr", {15'd0, pending}, 16'd0);
        chk("a53c_hold", tx_word, 16'hA53C);

        spi_busy = 1'b1;
        send(8'h11);
        send(8'h22);
        chk("1122_pending", {15'd0, pending}, 16'd1);
        starts = 0;
        count_starts(40);
        chk("1122_no_start_busy", starts[15:0], 16'd0);
        spi_busy = 1'b0;
        step(1);
        chk("1122_start", {15'd0, start}, 16'd1);
        chk("1122_word", tx_word, 16'h1122);
        step(1);
        chk("1122_start_once", {15'd0, start}, 16'd0);
        finish_xfer();
        chk("1122_pend_clr", {15'd0, pending}, 16'd0);

        spi_busy = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        chk("ovr_flag", {15'd0, overrun}, 16'd1);
        chk("ovr_word_kept", tx_word, 16'h1122);
        spi_busy = 1'b0;
        starts = 0;
        count_starts(3);
        chk("ovr_word_sent", tx_word, 16'h1122);
        spi_busy = 1'b1;
        step(3);
        spi_busy = 1'b0;
        count_starts(6);
        chk("ovr_one_start", starts[15:0], 16'd1);
        chk("ovr_pend_clr", {15'd0, pending}, 16'd0);
        chk("ovr_sticky", {15'd0, overrun}, 16'd1);

        send(8'h77);
        reset = 1'b0;
        #1;
        chk("rst_high_word", tx_word, 16'h0000);
        chk("rst_high_ovr", {15'd0, overrun}, 16'd0);
        chk("rst_high_pend", {15'd0, pending}, 16'd0);
        step(1);
        reset = 1'b1;
        send(8'h12);
        send(8'h34);
        chk("rst_pre_start", {15'd0, start}, 16'd1);
        chk("rst_pre_word", tx_word, 16'h1234);
        step(1);
        reset = 1'b0;
        #1;
        chk("rst_wb_word", tx_word, 16'h0000);
        chk("rst_wb_pend", {15'd0, pending}, 16'd0);
        chk("rst_wb_start", {15'd0, start}, 16'd0);
        step(1);
        reset = 1'b1;
        starts = 0;
        count_starts(5);
        chk("rst_no_start", starts[15:0], 16'd0);
        send(8'h9A);
        send(8'hBC);
        chk("fresh_start", {15'd0, start}, 16'd1);
        chk("fresh_word", tx_word, 16'h9ABC);

        step(1);
        spi_busy = 1'b1;
        step(1);
        send(8'hDE);
        spi_busy = 1'b0;
        send(8'hF0);
        chk("same_edge_word", tx_word, 16'hDEF0);
        chk("same_edge_pend", {15'd0, pending}, 16'd1);
        chk("same_edge_no_ovr", {15'd0, overrun}, 16'd0);
        step(1);
        chk("same_edge_start", {15'd0, start}, 16'd1);
        step(1);
        finish_xfer();
        chk("same_edge_clr", {15'd0, pending}, 16'd0);

`ifdef UART_RECV_TIMEOUT_EN
        errs = 0;
        send(8'h55);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (err_timeout) errs++;
        end
        chk("to_fired", {15'd0, err_timeout}, 16'd1);
        send(8'h01);
        if (err_timeout) errs++;
        send(8'h02);
        if (err_timeout) errs++;
        chk("to_one_pulse", errs[15:0], 16'd1);
        chk("to_word", tx_word, 16'h0102);
        chk("to_start", {15'd0, start}, 16'd1);
        step(1);
        finish_xfer();
        send(8'h66);
        step(9);
        send(8'h77);
        chk("to_race_word", tx_word, 16'h6677);
        chk("to_race_no_err", {15'd0, err_timeout}, 16'd0);
`else
        errs = 0;
        send(8'h55);
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (err_timeout) errs++;
        end
        send(8'h01);
        chk("noto_err", errs[15:0], 16'd0);
        chk("noto_word", tx_word, 16'h5501);
        chk("noto_start", {15'd0, start}, 16'd1);
`endif
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
